// File: rtl/qc_pkg.sv
// Shared fixed-point complex types and constants for the gate/state datapath and its sequencer.
package qc_pkg;

    localparam int WIDTH       = 16;
    localparam int FRAC_BITS   = 14;
    localparam logic [WIDTH-1:0] Q_ONE       = 16'h4000;
    localparam logic [WIDTH-1:0] Q_INV_SQRT2 = 16'h2D41;

    // a = real part, b = imaginary part, both signed Q2.14
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } complexNum;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_APPLY = 3'd3,
        S_DONE  = 3'd4
    } gsc_state_e;

endpackage

// File: rtl/gateStateMult.sv
// Combinational 2^N x 2^N complex matrix times complex vector, Q2.14 in and out.
// Products are summed at full precision, then floor-shifted and wrapped to 16 bits.
module gateStateMult
    import qc_pkg::*;
#(
    parameter  int N   = 2,
    localparam int DIM = 2**N
) (
    input  complexNum [DIM-1:0][DIM-1:0] gate_i,
    input  complexNum [DIM-1:0]          state_i,
    output complexNum [DIM-1:0]          result_o
);

    localparam int ACC_W = 2*WIDTH + N + 2;

    logic signed [ACC_W-1:0] acc_re [DIM];
    logic signed [ACC_W-1:0] acc_im [DIM];

    always_comb begin
        for (int r = 0; r < DIM; r++) begin
            acc_re[r] = '0;
            acc_im[r] = '0;
            for (int c = 0; c < DIM; c++) begin
                acc_re[r] = acc_re[r]
                          + ACC_W'($signed(gate_i[r][c].a) * $signed(state_i[c].a))
                          - ACC_W'($signed(gate_i[r][c].b) * $signed(state_i[c].b));
                acc_im[r] = acc_im[r]
                          + ACC_W'($signed(gate_i[r][c].a) * $signed(state_i[c].b))
                          + ACC_W'($signed(gate_i[r][c].b) * $signed(state_i[c].a));
            end
        end
    end

    always_comb begin
        for (int r = 0; r < DIM; r++) begin
            result_o[r].a = WIDTH'(acc_re[r] >>> FRAC_BITS);
            result_o[r].b = WIDTH'(acc_im[r] >>> FRAC_BITS);
        end
    end

endmodule

// File: rtl/gate_sequence_ctrl.sv
// Walks a gate program through the shared gate/state multiplier: fetch gate, hold operands
// for MULT_LAT cycles, capture the product as the new state, repeat until num_gates applied.
module gate_sequence_ctrl
    import qc_pkg::*;
#(
    parameter  int N         = 2,
    parameter  int MAX_GATES = 16,
    parameter  int MULT_LAT  = 1,
    localparam int DIM       = 2**N,
    localparam int AW        = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [AW:0]                   num_gates,
    input  complexNum [DIM-1:0]           init_state,
    output logic                          gate_rd,
    output logic [AW-1:0]                 gate_addr,
    input  complexNum [DIM-1:0][DIM-1:0]  gate_data,
    output complexNum [DIM-1:0]           mult_state,
    output complexNum [DIM-1:0][DIM-1:0]  mult_gate,
    input  complexNum [DIM-1:0]           mult_result,
    output complexNum [DIM-1:0]           state_out,
    output logic [AW:0]                   gate_count,
    output logic                          busy,
    output logic                          done,
    output gsc_state_e                    dbg_state
);

    localparam int LW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_GATES);

    gsc_state_e                   fsm_q,   fsm_d;
    complexNum [DIM-1:0]          st_q,    st_d;
    complexNum [DIM-1:0][DIM-1:0] gt_q,    gt_d;
    logic [AW:0]                  cnt_q,   cnt_d;
    logic [AW:0]                  idx_q,   idx_d;
    logic [AW:0]                  num_q,   num_d;
    logic [LW-1:0]                lat_q,   lat_d;
    logic [AW-1:0]                addr_q,  addr_d;

    // Gate memory handshake: gate_rd is a one-cycle request with gate_addr valid alongside it;
    // gate_data is taken unconditionally on the following cycle (fixed latency, no back-pressure).
    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        gt_d    = gt_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        num_d   = num_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        gate_rd = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    st_d  = init_state;
                    cnt_d = '0;
                    idx_d = '0;
                    num_d = (num_gates > MAX_CNT) ? MAX_CNT : num_gates;
                    if (num_gates == '0) begin
                        fsm_d = S_DONE;
                    end else begin
                        fsm_d  = S_FETCH;
                        addr_d = '0;
                    end
                end
            end
            S_FETCH: begin
                gate_rd = 1'b1;
                fsm_d   = S_WAIT;
            end
            S_WAIT: begin
                gt_d  = gate_data;
                lat_d = '0;
                fsm_d = S_APPLY;
            end
            S_APPLY: begin
                lat_d = lat_q + LW'(1);
                // Operands have been stable for MULT_LAT cycles on the last APPLY cycle
                if (lat_q == LW'(MULT_LAT - 1)) begin
                    st_d  = mult_result;
                    cnt_d = cnt_q + (AW+1)'(1);
                    idx_d = idx_q + (AW+1)'(1);
                    if (idx_q == num_q - (AW+1)'(1)) begin
                        fsm_d = S_DONE;
                    end else begin
                        fsm_d  = S_FETCH;
                        addr_d = idx_d[AW-1:0];
                    end
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q  <= S_IDLE;
            st_q   <= '0;
            gt_q   <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            num_q  <= '0;
            lat_q  <= '0;
            addr_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            gt_q   <= gt_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            num_q  <= num_d;
            lat_q  <= lat_d;
            addr_q <= addr_d;
        end
    end

    assign gate_addr  = addr_q;
    assign mult_state = st_q;
    assign mult_gate  = gt_q;
    assign state_out  = st_q;
    assign gate_count = cnt_q;
    assign busy       = (fsm_q != S_IDLE);
    assign done       = (fsm_q == S_DONE);
    assign dbg_state  = fsm_q;

endmodule
